stack_unit: RTL and testbench
=============================

# stack_unit

Parametrised stack-pointer unit for the 8051 core, successor to the single-byte SP logic. Holds SP as a true register, runs multi-byte push/pop bursts (LCALL/RET/interrupt push 2 bytes) with its own beat sequencer, and drives the internal-RAM address and strobes for each beat. Sits between the instruction decoder/ALU SFR write path and internal RAM; detects overflow/underflow against configurable bounds.

## Interface
- `SP_W`, 8, SP and RAM address width
- `RST_SP`, 8'h07, SP value after reset
- `SP_MIN`, 8'h07, lowest legal SP; pop at this value underflows
- `SP_MAX`, 8'hFF, highest legal SP; push at this value overflows
- `BURST_MAX`, 2, max beats per request (1..3)
- `SFR_ADDR`, 8'h81, SFR address of SP
- `clock` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-low
- `wr` in 1: SFR write strobe
- `wr_bit` in 1: bit-addressed write; SP not written when high
- `wr_addr` in 8: SFR write address
- `wr_data` in SP_W: SFR write data
- `push_req` in 1: start push burst
- `pop_req` in 1: start pop burst
- `burst_len` in 2: beats requested; 0 treated as 1, values above BURST_MAX clamped
- `clr_err` in 1: clears ovf/unf
- `busy` out 1: burst in progress
- `ram_addr` out SP_W: stack RAM address for current beat
- `ram_wr` out 1: push beat strobe
- `ram_rd` out 1: pop beat strobe
- `sp_out` out SP_W: registered SP
- `ovf` out 1: sticky overflow flag
- `unf` out 1: sticky underflow flag

## Operation
- States: IDLE, PUSH, POP (encoding in shared defines).
- IDLE: push_req accepted when busy=0 -> PUSH, beat counter = effective burst_len. pop_req -> POP likewise. Both high: push wins, pop dropped.
- PUSH beat: pre-increment. ram_addr = sp+1, ram_wr=1; at edge sp <= sp+1, counter--.
- POP beat: post-decrement. ram_addr = sp, ram_rd=1; at edge sp <= sp-1, counter--.
- Counter reaches 0 after last beat -> IDLE.
- Overflow: PUSH beat with sp==SP_MAX -> no ram_wr, sp unchanged, ovf<=1, burst aborted to IDLE. Underflow: POP beat with sp==SP_MIN -> no ram_rd, sp unchanged, unf<=1, abort.
- SFR write (wr & !wr_bit & wr_addr==SFR_ADDR): sp <= wr_data; highest priority. In PUSH/POP it aborts the burst (current beat strobe still asserted combinationally, but sp takes wr_data, state -> IDLE). No bounds check on SFR writes.
- Requests while busy are ignored (no queueing).
- clr_err clears both flags; a new error in the same cycle wins (flag stays 1).
- Arithmetic modulo 2^SP_W; only SP_MAX/SP_MIN bounds stop wrap.

## Timing
- Reset (reset low, async): sp=RST_SP, state IDLE, counter 0, busy=0, ram_wr=ram_rd=0, ram_addr=RST_SP, ovf=unf=0.
- Request sampled at edge of cycle N; beats occupy cycles N+1..N+k; busy=1 exactly in those cycles; back-to-back request accepted in cycle N+k+1 earliest... request may be presented in N+k (sampled when busy drops at that edge? no) — rule: accepted only in a cycle with busy=0.
- ram_addr/ram_wr/ram_rd combinational from state and sp; sp_out updates at the edge ending each beat.
- ovf/unf set at the edge ending the faulting beat.
- Reset asserted mid-burst: immediate return to reset values; no further strobes.

## Structure
- Shared define file (define_opcodes.v): SFR_SP, RST_SP, state encodings ST_IDLE/ST_PUSH/ST_POP.
- Single module; no sub-module needed (sequencer and SP register are one small FSM).

## Test plan
- Reset release: sp_out=0x07, busy=0, flags 0; SFR write 0x30 -> sp_out=0x30 next cycle; same with wr_bit=1 -> unchanged.
- Push burst_len=2 from sp=0x07: cycles N+1,N+2 ram_wr with ram_addr 0x08,0x09; sp_out=0x09; busy high 2 cycles.
- Pop burst_len=2 from 0x09: ram_rd at 0x09,0x08; sp_out=0x07; then pop len 1 -> no ram_rd, unf=1, sp 0x07.
- sp=0xFE, push len 2: ram_wr at 0xFF, sp=0xFF, second beat suppressed, ovf=1, busy drops after 2 cycles; clr_err -> ovf=0.
- push_req and pop_req together at sp=0x20 len 1: push only, ram_addr 0x21, sp 0x21.
- SFR write 0x50 during second beat of push from 0x10: sp_out=0x50, state IDLE; reset low mid-burst -> sp_out=0x07 asynchronously.

Source files
------------

// File: rtl/stack_unit_pkg.sv
// Shared types and helpers for the 8051 stack-pointer unit:
// sequencer state encoding and burst-length normalisation.
package stack_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PUSH = 2'd1,
    ST_POP  = 2'd2
  } state_e;

  localparam int CNT_W = 2;

  // A zero request means one beat; anything above the configured limit is clamped.
  function automatic logic [CNT_W-1:0] eff_len(input logic [1:0] req,
                                               input int unsigned burst_max);
    logic [CNT_W-1:0] lim;
    logic [CNT_W-1:0] len;
    lim = CNT_W'(burst_max);
    len = req;
    if (req == 2'd0) begin
      len = 2'd1;
    end else if (req > lim) begin
      len = lim;
    end else begin
      len = req;
    end
    return len;
  endfunction

endpackage

// File: rtl/stack_unit.sv
// Stack-pointer register with a push/pop beat sequencer driving internal-RAM
// address and strobes, bounds-checked against SP_MIN/SP_MAX.
module stack_unit
  import stack_unit_pkg::*;
#(
  parameter int unsigned          SP_W      = 8,
  parameter logic [SP_W-1:0]      RST_SP    = 8'h07,
  parameter logic [SP_W-1:0]      SP_MIN    = 8'h07,
  parameter logic [SP_W-1:0]      SP_MAX    = 8'hFF,
  parameter int unsigned          BURST_MAX = 2,
  parameter logic [7:0]           SFR_ADDR  = 8'h81
) (
  input  logic            clock_i,
  input  logic            reset_ni,
  input  logic            wr_i,
  input  logic            wr_bit_i,
  input  logic [7:0]      wr_addr_i,
  input  logic [SP_W-1:0] wr_data_i,
  input  logic            push_req_i,
  input  logic            pop_req_i,
  input  logic [1:0]      burst_len_i,
  input  logic            clr_err_i,
  output logic            busy_o,
  output logic [SP_W-1:0] ram_addr_o,
  output logic            ram_wr_o,
  output logic            ram_rd_o,
  output logic [SP_W-1:0] sp_out_o,
  output logic            ovf_o,
  output logic            unf_o
);

  localparam logic [SP_W-1:0] SP_ONE = SP_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SP_W-1:0]  sp_q, sp_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic             sfr_wr_s;
  logic [SP_W-1:0]  addr_s;
  logic             wr_s;
  logic             rd_s;
  logic [CNT_W-1:0] len_s;

  assign sfr_wr_s = wr_i & ~wr_bit_i & (wr_addr_i == SFR_ADDR);
  assign len_s    = eff_len(burst_len_i, BURST_MAX);

  // Next-state, SP arithmetic, error flags and per-beat RAM strobes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sp_d    = sp_q;
    ovf_d   = ovf_q & ~clr_err_i;
    unf_d   = unf_q & ~clr_err_i;
    addr_s  = sp_q;
    wr_s    = 1'b0;
    rd_s    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (push_req_i) begin
          state_d = ST_PUSH;
          cnt_d   = len_s;
        end else if (pop_req_i) begin
          state_d = ST_POP;
          cnt_d   = len_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PUSH: begin
        addr_s = sp_q + SP_ONE;
        if (sp_q == SP_MAX) begin
          ovf_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          wr_s  = 1'b1;
          sp_d  = sp_q + SP_ONE;
          cnt_d = cnt_q - 2'd1;
          if (cnt_q == 2'd1) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_PUSH;
          end
        end
      end
      ST_POP: begin
        addr_s = sp_q;
        if (sp_q == SP_MIN) begin
          unf_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          rd_s  = 1'b1;
          sp_d  = sp_q - SP_ONE;
          cnt_d = cnt_q - 2'd1;
          if (cnt_q == 2'd1) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_POP;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // The SFR write owns SP this cycle; a running burst is abandoned, but a
    // request seen in IDLE still starts from the freshly written value.
    if (sfr_wr_s) begin
      sp_d = wr_data_i;
      if (state_q != ST_IDLE) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        state_d = state_d;
      end
    end else begin
      sp_d = sp_d;
    end
  end

  // State, beat counter, SP and sticky error flags.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sp_q    <= RST_SP;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sp_q    <= sp_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign busy_o     = (state_q != ST_IDLE);
  assign ram_addr_o = addr_s;
  assign ram_wr_o   = wr_s;
  assign ram_rd_o   = rd_s;
  assign sp_out_o   = sp_q;
  assign ovf_o      = ovf_q;
  assign unf_o      = unf_q;

endmodule

// File: tb/tb_stack_unit.sv
// Directed, table-driven bench for stack_unit: one row per clock cycle,
// plus hand-written sequences for SFR abort and asynchronous reset.
module tb_stack_unit;

  logic       clock_i = 1'b0;
  logic       reset_ni;
  logic       wr_i, wr_bit_i, push_req_i, pop_req_i, clr_err_i;
  logic [7:0] wr_addr_i, wr_data_i;
  logic [1:0] burst_len_i;
  logic       busy_o, ram_wr_o, ram_rd_o, ovf_o, unf_o;
  logic [7:0] ram_addr_o, sp_out_o;

  int n_tests = 0;
  int n_fail  = 0;

  stack_unit dut (
    .clock_i    (clock_i),
    .reset_ni   (reset_ni),
    .wr_i       (wr_i),
    .wr_bit_i   (wr_bit_i),
    .wr_addr_i  (wr_addr_i),
    .wr_data_i  (wr_data_i),
    .push_req_i (push_req_i),
    .pop_req_i  (pop_req_i),
    .burst_len_i(burst_len_i),
    .clr_err_i  (clr_err_i),
    .busy_o     (busy_o),
    .ram_addr_o (ram_addr_o),
    .ram_wr_o   (ram_wr_o),
    .ram_rd_o   (ram_rd_o),
    .sp_out_o   (sp_out_o),
    .ovf_o      (ovf_o),
    .unf_o      (unf_o)
  );

  always #5 clock_i = ~clock_i;

  typedef struct {
    logic       wr;
    logic       wr_bit;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       push;
    logic       pop;
    logic [1:0] len;
    logic       clr;
    logic       e_busy;
    logic [7:0] e_addr;
    logic       e_wr;
    logic       e_rd;
    logic [7:0] e_sp;
    logic       e_ovf;
    logic       e_unf;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic wr, input logic wb, input logic [7:0] wa, input logic [7:0] wd,
                     input logic pu, input logic po, input logic [1:0] ln, input logic cl,
                     input logic eb, input logic [7:0] ea, input logic ew, input logic er,
                     input logic [7:0] es, input logic eo, input logic eu);
    vec_t v;
    v.wr = wr; v.wr_bit = wb; v.wr_addr = wa; v.wr_data = wd;
    v.push = pu; v.pop = po; v.len = ln; v.clr = cl;
    v.e_busy = eb; v.e_addr = ea; v.e_wr = ew; v.e_rd = er;
    v.e_sp = es; v.e_ovf = eo; v.e_unf = eu;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic drive(input logic wr, input logic wb, input logic [7:0] wa, input logic [7:0] wd,
                       input logic pu, input logic po, input logic [1:0] ln, input logic cl);
    wr_i = wr; wr_bit_i = wb; wr_addr_i = wa; wr_data_i = wd;
    push_req_i = pu; pop_req_i = po; burst_len_i = ln; clr_err_i = cl;
  endtask

  task automatic idle_in();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic check_all(input string tag, input logic eb, input logic [7:0] ea, input logic ew,
                           input logic er, input logic [7:0] es, input logic eo, input logic eu);
    check({tag, ".busy"}, {7'd0, busy_o}, {7'd0, eb});
    check({tag, ".addr"}, ram_addr_o, ea);
    check({tag, ".ram_wr"}, {7'd0, ram_wr_o}, {7'd0, ew});
    check({tag, ".ram_rd"}, {7'd0, ram_rd_o}, {7'd0, er});
    check({tag, ".sp"}, sp_out_o, es);
    check({tag, ".ovf"}, {7'd0, ovf_o}, {7'd0, eo});
    check({tag, ".unf"}, {7'd0, unf_o}, {7'd0, eu});
  endtask

  initial begin
    reset_ni = 1'b0;
    idle_in();

    //   wr wb addr   data   pu po len cl | busy addr  w  r  sp     ov un
    add(0, 0, 8'h00, 8'h00, 0, 0, 2'd0, 0,  0, 8'h07, 0, 0, 8'h07, 0, 0); // reset state
    add(1, 0, 8'h81, 8'h30, 0, 0, 2'd0, 0,  0, 8'h07, 0, 0, 8'h07, 0, 0); // SFR write 0x30
    add(0, 0, 8'h00, 8'h00, 0, 0, 2'd0, 0,  0, 8'h30, 0, 0, 8'h30, 0, 0);
    add(1, 1, 8'h81, 8'h55, 0, 0, 2'd0, 0,  0, 8'h30, 0, 0, 8'h30, 0, 0); // bit write ignored
    add(1, 0, 8'h80, 8'h66, 0, 0, 2'd0, 0,  0, 8'h30, 0, 0, 8'h30, 0, 0); // other SFR ignored
    add(1, 0, 8'h81, 8'h07, 0, 0, 2'd0, 0,  0, 8'h30, 0, 0, 8'h30, 0, 0);
    add(0, 0, 8'h00, 8'h00, 1, 0, 2'd2, 0,  0, 8'h07, 0, 0, 8'h07, 0, 0); // push x2
    add(0, 0, 8'h00, 8'h00, 0, 0, 2'd0, 0,  1, 8'h08, 1, 0, 8'h07, 0, 0);
    add(0, 0, 8'h00, 8'h00, 0, 0, 2'd0, 0,  1, 8'h09, 1, 0, 8'h08, 0, 0);
    add(0, 0, 8'h00, 8'h00, 1, 0, 2'd2, 0,  0, 8'h09, 0, 0, 8'h09, 0, 0); // pop x2 below
    add(0, 0, 8'h00, 8'h00, 0, 0, 2'd0, 0,  1, 8'h0A, 1, 0, 8'h09, 0, 0);
    add(0, 0, 8'h00, 8'h00, 0, 0, 2'd0, 0,  1, 8'h0B, 1, 0, 8'h0A, 0, 0);
    add(1, 0, 8'h81, 8'h09, 0, 1, 2'd2, 0,  0, 8'h0B, 0, 0, 8'h0B, 0, 0); // SFR 0x09 + pop x2
    add(0, 0, 8'h00, 8'h00, 0, 0, 2'd0, 0,  1, 8'h09, 0, 1, 8'h09, 0, 0);
    add(0, 0, 8'h00, 8'h00, 0, 0, 2'd0, 0,  1, 8'h08, 0, 1, 8'h08, 0, 0);
    add(0, 0, 8'h00, 8'h00, 0, 1, 2'd1, 0,  0, 8'h07, 0, 0, 8'h07, 0, 0); // pop at SP_MIN
    add(0, 0, 8'h00, 8'h00, 0, 0, 2'd0, 0,  1, 8'h07, 0, 0, 8'h07, 0, 0);
    add(0, 0, 8'h00, 8'h00, 0, 0, 2'd0, 1,  0, 8'h07, 0, 0, 8'h07, 0, 1); // clr_err
    add(1, 0, 8'h81, 8'hFE, 0, 0, 2'd0, 0,  0, 8'h07, 0, 0, 8'h07, 0, 0);
    add(0, 0, 8'h00, 8'h00, 1, 0, 2'd2, 0,  0, 8'hFE, 0, 0, 8'hFE, 0, 0); // push x2 at 0xFE
    add(0, 0, 8'h00, 8'h00, 0, 0, 2'd0, 0,  1, 8'hFF, 1, 0, 8'hFE, 0, 0);
    add(0, 0, 8'h00, 8'h00, 0, 0, 2'd0, 0,  1, 8'h00, 0, 0, 8'hFF, 0, 0); // overflow beat
    add(0, 0, 8'h00, 8'h00, 0, 0, 2'd0, 1,  0, 8'hFF, 0, 0, 8'hFF, 1, 0);
    add(1, 0, 8'h81, 8'h20, 0, 0, 2'd0, 0,  0, 8'hFF, 0, 0, 8'hFF, 0, 0);
    add(0, 0, 8'h00, 8'h00, 1, 1, 2'd1, 0,  0, 8'h20, 0, 0, 8'h20, 0, 0); // push and pop together
    add(0, 0, 8'h00, 8'h00, 0, 0, 2'd0, 0,  1, 8'h21, 1, 0, 8'h20, 0, 0);
    add(0, 0, 8'h00, 8'h00, 1, 0, 2'd3, 0,  0, 8'h21, 0, 0, 8'h21, 0, 0); // len 3 clamps to 2
    add(0, 0, 8'h00, 8'h00, 0, 0, 2'd0, 0,  1, 8'h22, 1, 0, 8'h21, 0, 0);
    add(0, 0, 8'h00, 8'h00, 0, 1, 2'd1, 0,  1, 8'h23, 1, 0, 8'h22, 0, 0); // pop while busy
    add(0, 0, 8'h00, 8'h00, 0, 0, 2'd0, 0,  0, 8'h23, 0, 0, 8'h23, 0, 0);
    add(0, 0, 8'h00, 8'h00, 1, 0, 2'd0, 0,  0, 8'h23, 0, 0, 8'h23, 0, 0); // len 0 means 1
    add(0, 0, 8'h00, 8'h00, 0, 0, 2'd0, 0,  1, 8'h24, 1, 0, 8'h23, 0, 0);
    add(0, 0, 8'h00, 8'h00, 0, 0, 2'd0, 0,  0, 8'h24, 0, 0, 8'h24, 0, 0);

    #12;
    reset_ni = 1'b1;
    @(posedge clock_i);
    #1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].wr, tbl[i].wr_bit, tbl[i].wr_addr, tbl[i].wr_data,
            tbl[i].push, tbl[i].pop, tbl[i].len, tbl[i].clr);
      @(negedge clock_i);
      check_all($sformatf("row%0d", i), tbl[i].e_busy, tbl[i].e_addr, tbl[i].e_wr,
                tbl[i].e_rd, tbl[i].e_sp, tbl[i].e_ovf, tbl[i].e_unf);
      @(posedge clock_i);
      #1;
    end

    // SFR write in the second beat of a push from 0x10 aborts the burst.
    drive(1'b1, 1'b0, 8'h81, 8'h10, 1'b0, 1'b0, 2'd0, 1'b0);
    @(posedge clock_i); #1;
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 2'd2, 1'b0);
    @(posedge clock_i); #1;
    idle_in();
    @(negedge clock_i);
    check_all("abort.beat1", 1'b1, 8'h11, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0);
    @(posedge clock_i); #1;
    drive(1'b1, 1'b0, 8'h81, 8'h50, 1'b0, 1'b0, 2'd0, 1'b0);
    @(negedge clock_i);
    check_all("abort.beat2", 1'b1, 8'h12, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
    @(posedge clock_i); #1;
    idle_in();
    @(negedge clock_i);
    check_all("abort.after", 1'b0, 8'h50, 1'b0, 1'b0, 8'h50, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a push burst.
    @(posedge clock_i); #1;
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 2'd2, 1'b0);
    @(posedge clock_i); #1;
    idle_in();
    check_all("rst.beat1", 1'b1, 8'h51, 1'b1, 1'b0, 8'h50, 1'b0, 1'b0);
    #2;
    reset_ni = 1'b0;
    #1;
    check_all("rst.async", 1'b0, 8'h07, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0);
    @(posedge clock_i); #1;
    check_all("rst.held", 1'b0, 8'h07, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0);
    reset_ni = 1'b1;
    @(posedge clock_i); #1;
    check_all("rst.release", 1'b0, 8'h07, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
